// File: rtl/uart_receiver_if.sv
// Serial receive port: line, enable and oversample tick in; byte and status flags out.
interface uart_receiver_if;
    logic       sample_ENABLE;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    // Driver side: owns the line, enable and tick.
    modport master (
        output sample_ENABLE,
        output Rx_EN,
        output RxD,
        input  Rx_DATA,
        input  Rx_VALID,
        input  Rx_PERROR,
        input  Rx_FERROR
    );

    // Receiver side.
    modport slave (
        input  sample_ENABLE,
        input  Rx_EN,
        input  RxD,
        output Rx_DATA,
        output Rx_VALID,
        output Rx_PERROR,
        output Rx_FERROR
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled, 8 data bits LSB first, one parity bit, one stop bit.
// Status outputs are registered and only change when a frame completes.
module uart_receiver #(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    uart_receiver_if.slave rx
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic       rxd_meta_q, rxd_s_q;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       perr_q, perr_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perror_q, perror_d;
    logic       ferror_q, ferror_d;
    logic       mid_tick, end_tick;

    // 8th tick lands mid start bit; every 16th tick after that lands mid-bit.
    assign mid_tick = rx.sample_ENABLE && (tick_q == 4'd7);
    assign end_tick = rx.sample_ENABLE && (tick_q == 4'd15);

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rx.RxD;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped enable overrides everything.
    always_comb begin
        state_d = state_q;
        if (!rx.Rx_EN) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (!rxd_s_q) state_d = StStart;
                StStart:  if (mid_tick) state_d = rxd_s_q ? StIdle : StData;
                StData:   if (end_tick && (bit_idx_q == 3'd7)) state_d = StParity;
                StParity: if (end_tick) state_d = StStop;
                StStop:   if (end_tick) state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Datapath and output next-state: counter, shifter, parity and frame results.
    always_comb begin
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        data_d    = data_q;
        perror_d  = perror_q;
        ferror_d  = ferror_q;
        valid_d   = 1'b0;

        // Counter restarts on every state entry and never runs while idle.
        if (!rx.Rx_EN || (state_d != state_q) || (state_q == StIdle)) begin
            tick_d = 4'd0;
        end else if (rx.sample_ENABLE) begin
            tick_d = tick_q + 4'd1;
        end

        if (!rx.Rx_EN) begin
            bit_idx_d = 3'd0;
            shift_d   = 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    bit_idx_d = 3'd0;
                end
                StStart: begin
                end
                StData: begin
                    if (end_tick) begin
                        shift_d[bit_idx_q] = rxd_s_q;
                        bit_idx_d          = bit_idx_q + 3'd1;
                    end
                end
                StParity: begin
                    if (end_tick) begin
                        perr_d = ((^shift_q) ^ rxd_s_q) != ODD_PARITY;
                    end
                end
                StStop: begin
                    // All results publish together on the stop-sample edge.
                    if (end_tick) begin
                        data_d   = shift_q;
                        perror_d = perr_q;
                        ferror_d = ~rxd_s_q;
                        valid_d  = ~perr_q & rxd_s_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tick_q    <= 4'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            perr_q    <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            perror_q  <= 1'b0;
            ferror_q  <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perror_q  <= perror_d;
            ferror_q  <= ferror_d;
        end
    end

    assign rx.Rx_DATA   = data_q;
    assign rx.Rx_VALID  = valid_q;
    assign rx.Rx_PERROR = perror_q;
    assign rx.Rx_FERROR = ferror_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: one task per scenario, inline comparisons.
module tb_uart_receiver;

    logic clock;
    logic reset;
    uart_receiver_if u_if ();

    uart_receiver #(
        .ODD_PARITY(1'b0)
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .rx   (u_if.slave)
    );

    int errors   = 0;
    int checks   = 0;
    int vcount   = 0;
    logic [7:0] cap [0:3];
    bit se_always = 1'b0;
    int bit_clks  = 64;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Oversample tick: every 4th clock, or continuously when se_always is set.
    initial begin
        int phase;
        phase = 0;
        u_if.sample_ENABLE = 1'b0;
        forever begin
            @(negedge clock);
            if (se_always) begin
                u_if.sample_ENABLE = 1'b1;
            end else begin
                u_if.sample_ENABLE = (phase == 3);
                phase = (phase + 1) % 4;
            end
        end
    end

    // Valid-pulse monitor: counts high cycles and captures the byte on each.
    initial begin
        forever begin
            @(negedge clock);
            if (u_if.Rx_VALID === 1'b1) begin
                if (vcount < 4) cap[vcount] = u_if.Rx_DATA;
                vcount = vcount + 1;
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drive one frame. stop_low_clks: how long a 0 stop bit stays low.
    // kill_kind 1 = pulse reset at clock kill_at, 2 = drop Rx_EN at kill_at.
    task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit stop_bit,
                              input int stop_low_clks, input int kill_at, input int kill_kind);
        logic [10:0] bits;
        int clk_n;
        bits  = {stop_bit, (^d) ^ flip_par, d, 1'b0};
        clk_n = 0;
        for (int b = 0; b < 11; b++) begin
            u_if.RxD = bits[b];
            for (int c = 0; c < bit_clks; c++) begin
                if (b == 10 && !stop_bit && c == stop_low_clks) u_if.RxD = 1'b1;
                if (clk_n == kill_at && kill_kind == 1) begin
                    reset    = 1'b0;
                    u_if.RxD = 1'b1;
                    wait_clks(3);
                    reset = 1'b1;
                    return;
                end
                if (clk_n == kill_at && kill_kind == 2) u_if.Rx_EN = 1'b0;
                @(negedge clock);
                clk_n++;
            end
        end
        u_if.RxD = 1'b1;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        u_if.RxD    = 1'b1;
        u_if.Rx_EN  = 1'b1;
        wait_clks(4);
        reset = 1'b1;
        wait_clks(2);
        checks++; if (u_if.Rx_DATA !== 8'h00) begin errors++;
            $display("FAIL reset_data got=%h exp=00", u_if.Rx_DATA); end
        checks++; if (u_if.Rx_VALID !== 1'b0) begin errors++;
            $display("FAIL reset_valid got=%b exp=0", u_if.Rx_VALID); end
        checks++; if (u_if.Rx_PERROR !== 1'b0) begin errors++;
            $display("FAIL reset_perror got=%b exp=0", u_if.Rx_PERROR); end
        checks++; if (u_if.Rx_FERROR !== 1'b0) begin errors++;
            $display("FAIL reset_ferror got=%b exp=0", u_if.Rx_FERROR); end
    endtask

    task automatic test_good_frame();
        vcount = 0;
        send_frame(8'hA5, 1'b0, 1'b1, 0, -1, 0);
        wait_clks(40);
        checks++; if (vcount !== 1) begin errors++;
            $display("FAIL good_valid_cycles got=%0d exp=1", vcount); end
        checks++; if (cap[0] !== 8'hA5) begin errors++;
            $display("FAIL good_cap got=%h exp=a5", cap[0]); end
        checks++; if (u_if.Rx_DATA !== 8'hA5) begin errors++;
            $display("FAIL good_data got=%h exp=a5", u_if.Rx_DATA); end
        checks++; if ({u_if.Rx_PERROR, u_if.Rx_FERROR} !== 2'b00) begin errors++;
            $display("FAIL good_flags got=%b%b exp=00", u_if.Rx_PERROR, u_if.Rx_FERROR); end
    endtask

    task automatic test_parity_error();
        vcount = 0;
        send_frame(8'h3C, 1'b1, 1'b1, 0, -1, 0);
        wait_clks(40);
        checks++; if (vcount !== 0) begin errors++;
            $display("FAIL perr_valid got=%0d exp=0", vcount); end
        checks++; if (u_if.Rx_DATA !== 8'h3C) begin errors++;
            $display("FAIL perr_data got=%h exp=3c", u_if.Rx_DATA); end
        checks++; if (u_if.Rx_PERROR !== 1'b1) begin errors++;
            $display("FAIL perr_flag got=%b exp=1", u_if.Rx_PERROR); end
        checks++; if (u_if.Rx_FERROR !== 1'b0) begin errors++;
            $display("FAIL perr_ferror got=%b exp=0", u_if.Rx_FERROR); end
    endtask

    task automatic test_framing_error();
        vcount = 0;
        // Stop bit low through its sample point, then high before the re-armed start check.
        send_frame(8'hFF, 1'b0, 1'b0, 48, -1, 0);
        wait_clks(80);
        checks++; if (vcount !== 0) begin errors++;
            $display("FAIL ferr_valid got=%0d exp=0", vcount); end
        checks++; if (u_if.Rx_FERROR !== 1'b1) begin errors++;
            $display("FAIL ferr_flag got=%b exp=1", u_if.Rx_FERROR); end
        checks++; if (u_if.Rx_PERROR !== 1'b0) begin errors++;
            $display("FAIL ferr_perror got=%b exp=0", u_if.Rx_PERROR); end
        checks++; if (u_if.Rx_DATA !== 8'hFF) begin errors++;
            $display("FAIL ferr_data got=%h exp=ff", u_if.Rx_DATA); end
        vcount = 0;
        send_frame(8'h01, 1'b0, 1'b1, 0, -1, 0);
        wait_clks(40);
        checks++; if (vcount !== 1) begin errors++;
            $display("FAIL recover_valid got=%0d exp=1", vcount); end
        checks++; if (u_if.Rx_DATA !== 8'h01) begin errors++;
            $display("FAIL recover_data got=%h exp=01", u_if.Rx_DATA); end
        checks++; if ({u_if.Rx_PERROR, u_if.Rx_FERROR} !== 2'b00) begin errors++;
            $display("FAIL recover_flags got=%b%b exp=00", u_if.Rx_PERROR, u_if.Rx_FERROR); end
    endtask

    task automatic test_glitch();
        vcount   = 0;
        u_if.RxD = 1'b0;
        wait_clks(12);
        u_if.RxD = 1'b1;
        wait_clks(120);
        checks++; if (vcount !== 0) begin errors++;
            $display("FAIL glitch_valid got=%0d exp=0", vcount); end
        checks++; if (u_if.Rx_DATA !== 8'h01) begin errors++;
            $display("FAIL glitch_data got=%h exp=01", u_if.Rx_DATA); end
        checks++; if ({u_if.Rx_PERROR, u_if.Rx_FERROR} !== 2'b00) begin errors++;
            $display("FAIL glitch_flags got=%b%b exp=00", u_if.Rx_PERROR, u_if.Rx_FERROR); end
    endtask

    task automatic test_back_to_back();
        vcount = 0;
        send_frame(8'h55, 1'b0, 1'b1, 0, -1, 0);
        send_frame(8'hAA, 1'b0, 1'b1, 0, -1, 0);
        wait_clks(40);
        checks++; if (vcount !== 2) begin errors++;
            $display("FAIL b2b_valid got=%0d exp=2", vcount); end
        checks++; if (cap[0] !== 8'h55) begin errors++;
            $display("FAIL b2b_first got=%h exp=55", cap[0]); end
        checks++; if (cap[1] !== 8'hAA) begin errors++;
            $display("FAIL b2b_second got=%h exp=aa", cap[1]); end
    endtask

    task automatic test_abort();
        vcount = 0;
        // Reset in the middle of data bit 4 (frame clock 5*64+32).
        send_frame(8'h0F, 1'b0, 1'b1, 0, 352, 1);
        wait_clks(800);
        checks++; if (vcount !== 0) begin errors++;
            $display("FAIL rst_abort_valid got=%0d exp=0", vcount); end
        checks++; if (u_if.Rx_DATA !== 8'h00) begin errors++;
            $display("FAIL rst_abort_data got=%h exp=00", u_if.Rx_DATA); end
        checks++; if ({u_if.Rx_PERROR, u_if.Rx_FERROR} !== 2'b00) begin errors++;
            $display("FAIL rst_abort_flags got=%b%b exp=00", u_if.Rx_PERROR, u_if.Rx_FERROR); end
        // Enable dropped mid-frame and held low until the line is idle again.
        send_frame(8'h5A, 1'b0, 1'b1, 0, 202, 2);
        wait_clks(40);
        u_if.Rx_EN = 1'b1;
        wait_clks(40);
        checks++; if (vcount !== 0) begin errors++;
            $display("FAIL en_abort_valid got=%0d exp=0", vcount); end
        checks++; if (u_if.Rx_DATA !== 8'h00) begin errors++;
            $display("FAIL en_abort_data got=%h exp=00", u_if.Rx_DATA); end
        send_frame(8'h81, 1'b0, 1'b1, 0, -1, 0);
        wait_clks(40);
        checks++; if (vcount !== 1) begin errors++;
            $display("FAIL post_abort_valid got=%0d exp=1", vcount); end
        checks++; if (u_if.Rx_DATA !== 8'h81) begin errors++;
            $display("FAIL post_abort_data got=%h exp=81", u_if.Rx_DATA); end
    endtask

    task automatic test_continuous_tick();
        se_always = 1'b1;
        bit_clks  = 16;
        wait_clks(4);
        vcount = 0;
        send_frame(8'hC3, 1'b0, 1'b1, 0, -1, 0);
        wait_clks(20);
        checks++; if (vcount !== 1) begin errors++;
            $display("FAIL cont_valid got=%0d exp=1", vcount); end
        checks++; if (u_if.Rx_DATA !== 8'hC3) begin errors++;
            $display("FAIL cont_data got=%h exp=c3", u_if.Rx_DATA); end
        se_always = 1'b0;
        bit_clks  = 64;
    endtask

    initial begin
        reset      = 1'b0;
        u_if.RxD   = 1'b1;
        u_if.Rx_EN = 1'b1;
        for (int i = 0; i < 4; i++) cap[i] = 8'h00;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_framing_error();
        test_glitch();
        test_back_to_back();
        test_abort();
        test_continuous_tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter ODD_PARITY, default 0, selects the parity check: 0 = even parity, 1 = odd parity.
REQ-002 clock  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 sample_ENABLE  input  1  single-clock oversampling tick at 16x baud, produced by the baud controller.
REQ-005 Rx_EN  input  1  receiver enable; when 0 the receiver is held idle.
REQ-006 RxD  input  1  asynchronous serial line; idles high.
REQ-007 Rx_DATA  output  8  last received data byte.
REQ-008 Rx_VALID  output  1  one-clock pulse marking a good frame.
REQ-009 Rx_PERROR  output  1  parity error flag for the last frame.
REQ-010 Rx_FERROR  output  1  framing (stop bit) error flag for the last frame.

Function
REQ-011 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1). Each bit lasts 16 sample_ENABLE ticks.
REQ-012 RxD SHALL pass through a two-flop synchronizer; all decisions below use the synchronized value (rxd_s), which has 2 clocks of latency.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, encoded in a 3-bit register.
REQ-014 A 4-bit tick counter SHALL advance only on clocks where sample_ENABLE=1 and be cleared on every state entry.
REQ-015 IDLE: on a clock where rxd_s=0 and Rx_EN=1 (falling edge not required), go to START and clear the tick counter.
REQ-016 START: on the 8th tick (mid-bit), if rxd_s=0 go to DATA; if rxd_s=1 treat it as a false start, return to IDLE, and leave all outputs unchanged.
REQ-017 DATA: on every 16th tick, shift rxd_s into bit index 0..7 (LSB first); after bit 7 go to PARITY.
REQ-018 PARITY: on the 16th tick, compute PERROR = (XOR of the 8 data bits ^ rxd_s) != ODD_PARITY, then go to STOP.
REQ-019 STOP: on the 16th tick, FERROR = ~rxd_s; update Rx_DATA, Rx_PERROR, Rx_FERROR together on that same clock edge; go to IDLE.
REQ-020 Rx_VALID SHALL be 1 for exactly the one clock following the stop-sample edge, only when PERROR=0 and FERROR=0; otherwise it stays 0.
REQ-021 Rx_DATA and the error flags SHALL hold their values until the next completed frame; a false start or an abort does not change them.
REQ-022 On STOP->IDLE, a low rxd_s on the next clock SHALL be accepted immediately as a new start (back-to-back frames).
REQ-023 Rx_EN=0 in any state SHALL force IDLE on the next edge and clear the tick counter and shift register, with no Rx_VALID pulse; outputs hold.
REQ-024 sample_ENABLE held continuously high SHALL be legal; the counter then advances every clock.
REQ-025 sample_ENABLE ticks arriving while in IDLE SHALL be ignored.

Reset
REQ-026 When reset=0 at a rising clock edge: state=IDLE; counter, bit index and shift register = 0; Rx_DATA=8'h00; Rx_VALID=0; Rx_PERROR=0; Rx_FERROR=0; both synchronizer flops=1.
REQ-027 Reset SHALL take priority over Rx_EN and sample_ENABLE; a reset mid-frame SHALL abort the frame with no Rx_VALID pulse.
REQ-028 No output SHALL change asynchronously to clock.

Verification
REQ-029 Bench drives sample_ENABLE every 4 clocks. Frame 8'hA5 with even parity bit 0 and stop 1 -> Rx_DATA=8'hA5, Rx_VALID pulses for 1 clock, both error flags 0.
REQ-030 Frame 8'h3C with the parity bit flipped to 1 -> Rx_PERROR=1, Rx_FERROR=0, Rx_DATA=8'h3C, no Rx_VALID.
REQ-031 Frame 8'hFF with stop bit 0 -> Rx_FERROR=1, no Rx_VALID; next good frame 8'h01 -> both flags clear and Rx_VALID pulses.
REQ-032 A RxD low glitch of 3 ticks -> FSM returns to IDLE; Rx_DATA, flags and Rx_VALID unchanged.
REQ-033 Two back-to-back frames 8'h55 then 8'hAA with no idle gap -> two Rx_VALID pulses with matching Rx_DATA.
REQ-034 Assert reset=0 during bit 4 of frame 8'h0F, then Rx_EN=0 during another frame -> no Rx_VALID, outputs return to or remain at their reset/held values, and a subsequent frame 8'h81 is received correctly.
